// File: rtl/segway_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segway_seq_pkg
// Description : Shared types and constants for the segway power-up / steer
//               sequencer: state encoding, rider thresholds, balance shifts
//               and timer widths for simulation and silicon builds.
// Revision    : 1.0 - initial release
// ============================================================================
package segway_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STEER = 2'd3
  } state_t;

  // Rider hysteresis window on the 13-bit load sum
  localparam logic [12:0] C_RIDER_ON_TH  = 13'h240;
  localparam logic [12:0] C_RIDER_OFF_TH = 13'h1C0;

  // Balance comparators: balanced if diff < sum>>2,
  // unbalanced if diff > sum - sum>>4
  localparam int C_BAL_SHIFT   = 2;
  localparam int C_UNBAL_SHIFT = 4;

  // Settle timer widths (terminal count = 2^W cycles)
  localparam int C_SETTLE_W_SIM = 10;
  localparam int C_SETTLE_W_SI  = 26;

  // Soft-start prescaler widths (ss_tmr step every 2^W cycles)
  localparam int C_SS_PRE_W_SIM = 4;
  localparam int C_SS_PRE_W_SI  = 12;

endpackage : segway_seq_pkg
`default_nettype wire

// File: rtl/segway_seq_ld_cell_cmp.sv
`default_nettype none
// ============================================================================
// Module      : ld_cell_cmp
// Description : Load-cell comparators. Registered rider-present flag with
//               hysteresis, plus combinational balanced / unbalanced flags
//               on the current load-cell inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ld_cell_cmp
  import segway_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_lft_ld,
  input  logic [11:0] i_rght_ld,
  output logic        o_rider,       // registered rider flag
  output logic        o_rider_nxt,   // value the flag takes at the next edge
  output logic        o_balanced,
  output logic        o_unbalanced
);

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic        w_rider_nxt;
  logic        r_rider;

  assign w_sum  = {1'b0, i_lft_ld} + {1'b0, i_rght_ld};
  assign w_diff = (i_lft_ld >= i_rght_ld) ? (i_lft_ld - i_rght_ld)
                                          : (i_rght_ld - i_lft_ld);

  assign o_balanced   = ({1'b0, w_diff} < (w_sum >> C_BAL_SHIFT));
  assign o_unbalanced = ({1'b0, w_diff} > (w_sum - (w_sum >> C_UNBAL_SHIFT)));

  // Hysteresis: set above the upper threshold, clear below the lower, else hold
  always_comb begin
    w_rider_nxt = r_rider;
    if (w_sum > C_RIDER_ON_TH)
      w_rider_nxt = 1'b1;
    else if (w_sum < C_RIDER_OFF_TH)
      w_rider_nxt = 1'b0;
  end

  // Rider flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rider <= 1'b0;
    else
      r_rider <= w_rider_nxt;
  end

  assign o_rider     = r_rider;
  assign o_rider_nxt = w_rider_nxt;

endmodule : ld_cell_cmp
`default_nettype wire

// File: rtl/segway_seq.sv
`default_nettype none
// ============================================================================
// Module      : segway_seq
// Description : Power-up / rider-settle / steer-enable sequencer with soft-
//               start ramp and sticky overspeed alarm. All outputs come
//               straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module segway_seq
  import segway_seq_pkg::*;
#(
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pwr_up_req,
  input  logic [11:0] i_lft_ld,
  input  logic [11:0] i_rght_ld,
  input  logic        i_too_fast,
  output logic        o_pwr_up,
  output logic [7:0]  o_ss_tmr,
  output logic        o_en_steer,
  output logic        o_rider_off,
  output logic        o_tf_alarm
);

  localparam int SETTLE_W = (FAST_SIM != 0) ? C_SETTLE_W_SIM : C_SETTLE_W_SI;
  localparam int PRE_W    = (FAST_SIM != 0) ? C_SS_PRE_W_SIM : C_SS_PRE_W_SI;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] w_settle_nxt;
  logic [PRE_W-1:0]    r_pre;
  logic [7:0]          r_ss;
  logic                r_tf;
  logic                w_rider;
  logic                w_rider_nxt;
  logic                w_bal;
  logic                w_unbal;

  ld_cell_cmp u_ld_cell_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lft_ld     (i_lft_ld),
    .i_rght_ld    (i_rght_ld),
    .o_rider      (w_rider),
    .o_rider_nxt  (w_rider_nxt),
    .o_balanced   (w_bal),
    .o_unbalanced (w_unbal)
  );

  // Next-state and settle-timer logic. Rider decisions use the flag's next
  // value so that rider loss and the state change land on the same edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    if (!i_pwr_up_req) begin
      w_state_nxt  = ST_OFF;
      w_settle_nxt = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nxt  = ST_IDLE;
          w_settle_nxt = '0;
        end
        ST_IDLE: begin
          w_settle_nxt = '0;
          if (w_rider_nxt)
            w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (!w_rider_nxt) begin
            w_state_nxt  = ST_IDLE;
            w_settle_nxt = '0;
          end else if (w_bal) begin
            if (&r_settle) begin
              w_state_nxt  = ST_STEER;
              w_settle_nxt = '0;
            end else begin
              w_settle_nxt = r_settle + SETTLE_W'(1);
            end
          end else begin
            w_settle_nxt = '0;
          end
        end
        ST_STEER: begin
          w_settle_nxt = '0;
          if (!w_rider_nxt)
            w_state_nxt = ST_IDLE;
          else if (w_unbal)
            w_state_nxt = ST_WAIT;
        end
        default: begin
          w_state_nxt  = ST_OFF;
          w_settle_nxt = '0;
        end
      endcase
    end
  end

  // State and settle-timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // Soft-start ramp: prescaled, saturating at 255, cleared only by power-down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_ss  <= 8'h00;
    end else if (!i_pwr_up_req || (r_state == ST_OFF)) begin
      r_pre <= '0;
      r_ss  <= 8'h00;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
      if ((&r_pre) && (r_ss != 8'hFF))
        r_ss <= r_ss + 8'd1;
    end
  end

  // Sticky overspeed alarm; power-down has priority over a coincident set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tf <= 1'b0;
    else if (!i_pwr_up_req || (r_state == ST_OFF))
      r_tf <= 1'b0;
    else if (i_too_fast && (r_state == ST_STEER))
      r_tf <= 1'b1;
  end

  assign o_pwr_up    = (r_state != ST_OFF);
  assign o_en_steer  = (r_state == ST_STEER) && !r_tf;
  assign o_ss_tmr    = r_ss;
  assign o_rider_off = !w_rider;
  assign o_tf_alarm  = r_tf;

endmodule : segway_seq
`default_nettype wire

// File: tb/tb_segway_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_segway_seq
// Description : Directed self-checking bench for segway_seq (FAST_SIM = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segway_seq;

  logic        clk;
  logic        rst_n;
  logic        i_pwr_up_req;
  logic [11:0] i_lft_ld;
  logic [11:0] i_rght_ld;
  logic        i_too_fast;
  logic        o_pwr_up;
  logic [7:0]  o_ss_tmr;
  logic        o_en_steer;
  logic        o_rider_off;
  logic        o_tf_alarm;

  int n_tests = 0;
  int n_fail  = 0;

  segway_seq #(.FAST_SIM(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pwr_up_req (i_pwr_up_req),
    .i_lft_ld     (i_lft_ld),
    .i_rght_ld    (i_rght_ld),
    .i_too_fast   (i_too_fast),
    .o_pwr_up     (o_pwr_up),
    .o_ss_tmr     (o_ss_tmr),
    .o_en_steer   (o_en_steer),
    .o_rider_off  (o_rider_off),
    .o_tf_alarm   (o_tf_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_tests++; if (o_pwr_up !== 1'b0) begin n_fail++; $display("FAIL reset_pwr_up: got %b want 0", o_pwr_up); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL reset_en_steer: got %b want 0", o_en_steer); end
    n_tests++; if (o_ss_tmr !== 8'h00) begin n_fail++; $display("FAIL reset_ss_tmr: got %h want 00", o_ss_tmr); end
    n_tests++; if (o_rider_off !== 1'b1) begin n_fail++; $display("FAIL reset_rider_off: got %b want 1", o_rider_off); end
    n_tests++; if (o_tf_alarm !== 1'b0) begin n_fail++; $display("FAIL reset_tf_alarm: got %b want 0", o_tf_alarm); end
    rst_n = 1'b1;
    tick(2);
    n_tests++; if (o_pwr_up !== 1'b0) begin n_fail++; $display("FAIL off_no_req: got %b want 0", o_pwr_up); end
  endtask

  task automatic test_power_up;
    i_pwr_up_req = 1'b1;
    tick(1);
    n_tests++; if (o_pwr_up !== 1'b1) begin n_fail++; $display("FAIL pwr_up_1clk: got %b want 1", o_pwr_up); end
    tick(15);
    n_tests++; if (o_ss_tmr !== 8'd0) begin n_fail++; $display("FAIL ss_tmr_15: got %0d want 0", o_ss_tmr); end
    tick(1);
    n_tests++; if (o_ss_tmr !== 8'd1) begin n_fail++; $display("FAIL ss_tmr_16: got %0d want 1", o_ss_tmr); end
    tick(4063);
    n_tests++; if (o_ss_tmr !== 8'd254) begin n_fail++; $display("FAIL ss_tmr_4079: got %0d want 254", o_ss_tmr); end
    tick(1);
    n_tests++; if (o_ss_tmr !== 8'd255) begin n_fail++; $display("FAIL ss_tmr_4080: got %0d want 255", o_ss_tmr); end
    tick(100);
    n_tests++; if (o_ss_tmr !== 8'd255) begin n_fail++; $display("FAIL ss_tmr_sat: got %0d want 255", o_ss_tmr); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL idle_en_steer: got %b want 0", o_en_steer); end
    n_tests++; if (o_rider_off !== 1'b1) begin n_fail++; $display("FAIL idle_rider_off: got %b want 1", o_rider_off); end
  endtask

  task automatic test_settle;
    i_lft_ld = 12'h300; i_rght_ld = 12'h300;
    tick(1);
    n_tests++; if (o_rider_off !== 1'b0) begin n_fail++; $display("FAIL settle_rider_on: got %b want 0", o_rider_off); end
    tick(1023);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL settle_early: got %b want 0", o_en_steer); end
    tick(1);
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL settle_done: got %b want 1", o_en_steer); end
  endtask

  task automatic test_step_off;
    i_lft_ld = 12'h0F8; i_rght_ld = 12'h0F8;   // sum 0x1F0, inside hysteresis
    tick(3);
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL hyst_en_steer: got %b want 1", o_en_steer); end
    n_tests++; if (o_rider_off !== 1'b0) begin n_fail++; $display("FAIL hyst_rider_off: got %b want 0", o_rider_off); end
    i_lft_ld = 12'h0D8; i_rght_ld = 12'h0D8;   // sum 0x1B0, below off threshold
    tick(1);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL stepoff_en_steer: got %b want 0", o_en_steer); end
    n_tests++; if (o_rider_off !== 1'b1) begin n_fail++; $display("FAIL stepoff_rider_off: got %b want 1", o_rider_off); end
    n_tests++; if (o_ss_tmr !== 8'd255) begin n_fail++; $display("FAIL stepoff_ss_kept: got %0d want 255", o_ss_tmr); end
    n_tests++; if (o_pwr_up !== 1'b1) begin n_fail++; $display("FAIL stepoff_pwr_up: got %b want 1", o_pwr_up); end
  endtask

  task automatic test_imbalance;
    i_lft_ld = 12'h300; i_rght_ld = 12'h300;
    tick(1);                                   // IDLE -> WAIT
    tick(599);
    i_lft_ld = 12'h500; i_rght_ld = 12'h080;   // not balanced for one cycle
    tick(1);
    n_tests++; if (o_rider_off !== 1'b0) begin n_fail++; $display("FAIL imbal_rider_off: got %b want 0", o_rider_off); end
    i_lft_ld = 12'h300; i_rght_ld = 12'h300;
    tick(1023);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL imbal_restart_early: got %b want 0", o_en_steer); end
    tick(1);
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL imbal_restart_done: got %b want 1", o_en_steer); end
  endtask

  task automatic test_unbal_steer;
    i_lft_ld = 12'hFFF; i_rght_ld = 12'h000;   // unbalanced, rider still present
    tick(1);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL unbal_to_wait: got %b want 0", o_en_steer); end
    n_tests++; if (o_rider_off !== 1'b0) begin n_fail++; $display("FAIL unbal_rider_off: got %b want 0", o_rider_off); end
    i_lft_ld = 12'h300; i_rght_ld = 12'h300;
    tick(1023);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL unbal_resettle_early: got %b want 0", o_en_steer); end
    tick(1);
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL unbal_resettle_done: got %b want 1", o_en_steer); end
  endtask

  task automatic test_overspeed;
    i_too_fast = 1'b1;
    tick(1);
    i_too_fast = 1'b0;
    n_tests++; if (o_tf_alarm !== 1'b1) begin n_fail++; $display("FAIL tf_set: got %b want 1", o_tf_alarm); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL tf_en_steer: got %b want 0", o_en_steer); end
    tick(5);
    n_tests++; if (o_tf_alarm !== 1'b1) begin n_fail++; $display("FAIL tf_sticky: got %b want 1", o_tf_alarm); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL tf_en_steer_hold: got %b want 0", o_en_steer); end
    n_tests++; if (o_pwr_up !== 1'b1) begin n_fail++; $display("FAIL tf_pwr_up: got %b want 1", o_pwr_up); end
    i_pwr_up_req = 1'b0; i_too_fast = 1'b1;    // power-down wins over overspeed
    tick(1);
    i_too_fast = 1'b0;
    n_tests++; if (o_pwr_up !== 1'b0) begin n_fail++; $display("FAIL pd_pwr_up: got %b want 0", o_pwr_up); end
    n_tests++; if (o_tf_alarm !== 1'b0) begin n_fail++; $display("FAIL pd_tf_alarm: got %b want 0", o_tf_alarm); end
    n_tests++; if (o_ss_tmr !== 8'd0) begin n_fail++; $display("FAIL pd_ss_tmr: got %0d want 0", o_ss_tmr); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL pd_en_steer: got %b want 0", o_en_steer); end
  endtask

  task automatic test_async_reset;
    i_pwr_up_req = 1'b1;
    tick(1026);                                // OFF->IDLE->WAIT, 1024 settle
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL pre_reset_steer: got %b want 1", o_en_steer); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (o_pwr_up !== 1'b0) begin n_fail++; $display("FAIL ares_pwr_up: got %b want 0", o_pwr_up); end
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL ares_en_steer: got %b want 0", o_en_steer); end
    n_tests++; if (o_ss_tmr !== 8'h00) begin n_fail++; $display("FAIL ares_ss_tmr: got %h want 00", o_ss_tmr); end
    n_tests++; if (o_rider_off !== 1'b1) begin n_fail++; $display("FAIL ares_rider_off: got %b want 1", o_rider_off); end
    n_tests++; if (o_tf_alarm !== 1'b0) begin n_fail++; $display("FAIL ares_tf_alarm: got %b want 0", o_tf_alarm); end
    #2 rst_n = 1'b1;
    #1;
    n_tests++; if (o_pwr_up !== 1'b0) begin n_fail++; $display("FAIL release_off: got %b want 0", o_pwr_up); end
    tick(1);
    n_tests++; if (o_pwr_up !== 1'b1) begin n_fail++; $display("FAIL cold_pwr_up: got %b want 1", o_pwr_up); end
    n_tests++; if (o_ss_tmr !== 8'd0) begin n_fail++; $display("FAIL cold_ss_tmr: got %0d want 0", o_ss_tmr); end
    tick(1024);
    n_tests++; if (o_en_steer !== 1'b0) begin n_fail++; $display("FAIL cold_settle_early: got %b want 0", o_en_steer); end
    tick(1);
    n_tests++; if (o_en_steer !== 1'b1) begin n_fail++; $display("FAIL cold_settle_done: got %b want 1", o_en_steer); end
  endtask

  initial begin
    rst_n        = 1'b0;
    i_pwr_up_req = 1'b0;
    i_lft_ld     = 12'h000;
    i_rght_ld    = 12'h000;
    i_too_fast   = 1'b0;
    #12;
    test_reset;
    test_power_up;
    test_settle;
    test_step_off;
    test_imbalance;
    test_unbal_steer;
    test_overspeed;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule : tb_segway_seq
`default_nettype wire

// File: doc/segway_seq.md
SEGWAY_SEQ -- requirements
Module: segway_seq

Interface
REQ-001 Parameter FAST_SIM, default 1: 1 = shortened timers for simulation, 0 = silicon timing.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pwr_up_req  input  1  power-up request from the authentication logic, level.
REQ-005 lft_ld  input  12  left load cell, unsigned.
REQ-006 rght_ld  input  12  right load cell, unsigned.
REQ-007 too_fast  input  1  overspeed flag from the speed math block.
REQ-008 pwr_up  output  1  enables the motor torque path.
REQ-009 ss_tmr  output  8  soft-start scale for the PID output, 0..255.
REQ-010 en_steer  output  1  enables steering torque mixing.
REQ-011 rider_off  output  1  no rider on the platform (hysteresis result).
REQ-012 tf_alarm  output  1  sticky overspeed alarm.

Function
REQ-013 The FSM SHALL have the states OFF, IDLE, WAIT and STEER.
  - pwr_up = (state != OFF).
  - en_steer = (state == STEER).
REQ-014 Load sum SHALL be 13-bit unsigned: sum = lft_ld + rght_ld.
  - diff SHALL be 12-bit: |lft_ld - rght_ld|.
REQ-015 Rider presence SHALL be a registered flag with hysteresis:
  - sets when sum > 0x240;
  - clears when sum < 0x1C0;
  - holds otherwise.
  - rider_off = !flag.
REQ-016 Balanced condition SHALL be diff < (sum >> 2).
  - Unbalanced condition SHALL be diff > sum - (sum >> 4).
  - Both are evaluated combinationally on the current inputs.
REQ-017 OFF -> IDLE SHALL occur on the edge where pwr_up_req = 1, so pwr_up is high the next cycle.
REQ-018 From any state, pwr_up_req = 0 SHALL force OFF next cycle, and SHALL clear:
  - the settle timer;
  - the ss_tmr prescaler;
  - ss_tmr itself.
REQ-019 IDLE -> WAIT SHALL occur when the rider flag is set.
REQ-020 In WAIT:
  - the settle timer SHALL count while balanced, and be cleared on any cycle not balanced;
  - when it reaches terminal count (2^10 cycles if FAST_SIM, else 2^26), the next state SHALL be STEER.
REQ-021 In STEER:
  - the unbalanced condition SHALL go to WAIT with the settle timer cleared;
  - the rider flag clearing SHALL go to IDLE.
REQ-022 In WAIT or STEER, the rider flag clearing SHALL go to IDLE with the settle timer cleared.
  - This takes priority over every transition except power-down.
REQ-023 In every non-OFF state, ss_tmr SHALL:
  - increment by 1 every 2^4 cycles (FAST_SIM) or every 2^12 cycles (silicon);
  - saturate at 255, never wrapping.
REQ-024 ss_tmr SHALL NOT be cleared by rider loss; only OFF or reset clears it.
REQ-025 tf_alarm SHALL set on any cycle where too_fast = 1 and state = STEER.
  - It SHALL clear only in OFF or on reset.
  - While tf_alarm = 1, en_steer SHALL be forced to 0; the state and pwr_up are unaffected.
REQ-026 If pwr_up_req falls and too_fast is high in the same cycle, power-down SHALL win: next state OFF, tf_alarm cleared.
REQ-027 Latency from any input change to an affected output SHALL be exactly one clock; there are no combinational input-to-output paths.

Reset
REQ-028 Asserting rst_n low SHALL immediately (asynchronously) produce:
  - state OFF;
  - pwr_up = 0, en_steer = 0, ss_tmr = 0x00;
  - rider_off = 1, tf_alarm = 0;
  - all counters zero.
REQ-029 Reset mid-WAIT or mid-STEER SHALL discard all progress.
  - After release, the block behaves as from cold start.

Structure
REQ-030 A shared package SHALL hold:
  - the state enum;
  - the thresholds 0x240, 0x1C0 and the balance shift amounts;
  - the settle and soft-start widths for both FAST_SIM values.
REQ-031 The rider-detect and balance comparator logic SHALL be one sub-module, named ld_cell_cmp.
  - Outputs: rider flag, balanced, unbalanced.
  - The FSM, timers and alarm live in segway_seq.

Verification
REQ-032 Power-up: pwr_up_req 0->1 with sum = 0 -> pwr_up = 1 after 1 clock; ss_tmr = 1 after 16 clocks; ss_tmr = 255 after 4080 clocks and holds at 255.
REQ-033 Settle: lft = rght = 0x300 while powered -> WAIT; en_steer rises after 1024 balanced cycles plus 1.
REQ-034 Imbalance: in WAIT, lft = 0x500, rght = 0x080 at cycle 600 for 1 cycle -> timer restarts; en_steer is delayed to 1024 cycles after the return to balance.
REQ-035 Rider step-off in STEER: sum 0x600 -> 0x1F0 -> state and outputs unchanged (hysteresis); sum -> 0x1B0 -> en_steer = 0 and rider_off = 1 after 1 clock; ss_tmr is retained.
REQ-036 Overspeed: too_fast pulse in STEER -> tf_alarm = 1 and en_steer = 0 persist after the pulse; pwr_up_req low -> OFF with tf_alarm = 0 and ss_tmr = 0.
REQ-037 Reset: rst_n low mid-STEER -> all outputs at reset values with no clock edge; release -> OFF.
